ball_ctrl: RTL and testbench

//   Ball/rally engine for the ping-pong LED game. Consumes the clk_game square wave from the

---
 rtl/ball_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ball_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// Ball/rally engine for the ping-pong LED game: re-times the game clock and buttons into
// single-cycle pulses, moves a one-hot ball across the LED bar, judges returns and keeps score.
module ball_ctrl #(
  parameter int N_LED       = 16,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int FLASH_STEPS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_game,
  input  logic               btn_l,
  input  logic               btn_r,
  output logic [N_LED-1:0]   led,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               ball_dir,
  output logic               game_over
);

  localparam int POS_W = $clog2(N_LED);
  localparam int FC_W  = $clog2(FLASH_STEPS + 1);

  localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0]   POS_MIN    = '0;
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [FC_W-1:0]    FLASH_LAST = FC_W'(FLASH_STEPS - 1);
  localparam logic [N_LED-1:0]   LED_ONE    = {{(N_LED-1){1'b0}}, 1'b1};

  localparam logic [2:0] SERVE_L = 3'd0;
  localparam logic [2:0] SERVE_R = 3'd1;
  localparam logic [2:0] MOVE    = 3'd2;
  localparam logic [2:0] FLASH   = 3'd3;
  localparam logic [2:0] OVER    = 3'd4;

  // Alternating pattern for the game-over display; odd=0 gives ..0101, odd=1 gives ..1010.
  function automatic logic [N_LED-1:0] alt_pattern(input logic odd);
    logic [N_LED-1:0] p;
    p = '0;
    for (int i = 0; i < N_LED; i++) p[i] = (i[0] == odd);
    return p;
  endfunction

  localparam logic [N_LED-1:0] PAT_A = alt_pattern(1'b0);
  localparam logic [N_LED-1:0] PAT_B = alt_pattern(1'b1);

  logic [1:0] cg_sync, bl_sync, br_sync;
  logic       cg_prev, bl_prev, br_prev;
  logic       step, hit_l, hit_r;

  logic [2:0]       state;
  logic [POS_W-1:0] pos;
  logic [FC_W-1:0]  flash_cnt;
  logic             scored_l;
  logic             over_phase;

  // NOTE: every sequential block uses non-blocking (<=) assignments so all flops sample
  // the same pre-edge values; blocking assignments here would chain the synchroniser stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cg_sync <= '0;
      bl_sync <= '0;
      br_sync <= '0;
      cg_prev <= 1'b0;
      bl_prev <= 1'b0;
      br_prev <= 1'b0;
    end else begin
      cg_sync <= {cg_sync[0], clk_game};
      bl_sync <= {bl_sync[0], btn_l};
      br_sync <= {br_sync[0], btn_r};
      cg_prev <= cg_sync[1];
      bl_prev <= bl_sync[1];
      br_prev <= br_sync[1];
    end
  end

  assign step  = cg_sync[1] & ~cg_prev;
  assign hit_l = bl_sync[1] & ~bl_prev;
  assign hit_r = br_sync[1] & ~br_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SERVE_L;
      pos        <= POS_MAX;
      ball_dir   <= 1'b0;
      score_l    <= '0;
      score_r    <= '0;
      flash_cnt  <= '0;
      scored_l   <= 1'b0;
      over_phase <= 1'b0;
    end else begin
      case (state)
        SERVE_L: begin
          pos      <= POS_MAX;
          ball_dir <= 1'b0;
          if (hit_l) state <= MOVE;
        end
        SERVE_R: begin
          pos      <= POS_MIN;
          ball_dir <= 1'b1;
          if (hit_r) state <= MOVE;
        end
        MOVE: begin
          // A return at the end LED takes priority over a step landing in the same cycle.
          if (!ball_dir) begin
            if (hit_r && pos == POS_MIN) begin
              ball_dir <= 1'b1;
            end else if (step) begin
              if (pos == POS_MIN) begin
                if (score_l != WIN) score_l <= score_l + SCORE_W'(1);
                scored_l  <= 1'b1;
                flash_cnt <= '0;
                state     <= FLASH;
              end else begin
                pos <= pos - POS_W'(1);
              end
            end
          end else begin
            if (hit_l && pos == POS_MAX) begin
              ball_dir <= 1'b0;
            end else if (step) begin
              if (pos == POS_MAX) begin
                if (score_r != WIN) score_r <= score_r + SCORE_W'(1);
                scored_l  <= 1'b0;
                flash_cnt <= '0;
                state     <= FLASH;
              end else begin
                pos <= pos + POS_W'(1);
              end
            end
          end
        end
        FLASH: begin
          if (step) begin
            if (flash_cnt == FLASH_LAST) begin
              flash_cnt <= '0;
              if (score_l == WIN || score_r == WIN) begin
                state <= OVER;
              end else if (scored_l) begin
                state    <= SERVE_R;
                pos      <= POS_MIN;
                ball_dir <= 1'b1;
              end else begin
                state    <= SERVE_L;
                pos      <= POS_MAX;
                ball_dir <= 1'b0;
              end
            end else begin
              flash_cnt <= flash_cnt + FC_W'(1);
            end
          end
        end
        OVER: begin
          if (step) over_phase <= ~over_phase;
        end
        default: state <= SERVE_L;
      endcase
    end
  end

  // LED bar is registered from the state of the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= LED_ONE << POS_MAX;
    end else begin
      case (state)
        FLASH:   led <= '1;
        OVER:    led <= over_phase ? PAT_B : PAT_A;
        default: led <= LED_ONE << pos;
      endcase
    end
  end

  assign game_over = (state == OVER);

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: expected outputs are queued as stimulus is applied and
// compared once the DUT has had time to react.
module tb_ball_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_game = 1'b0;
  logic        btn_l = 1'b0;
  logic        btn_r = 1'b0;
  logic [15:0] led;
  logic [3:0]  score_l, score_r;
  logic        ball_dir, game_over;

  ball_ctrl #(.N_LED(16), .SCORE_W(4), .WIN_SCORE(9), .FLASH_STEPS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_game (clk_game),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .led      (led),
    .score_l  (score_l),
    .score_r  (score_r),
    .ball_dir (ball_dir),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] led;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic        dir;
    logic        over;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] one = 16'h0001;
  logic [3:0]  sl = 4'd0;
  logic [3:0]  sr = 4'd0;

  task automatic expect_out(input logic [15:0] l, input logic [3:0] a, input logic [3:0] b,
                            input logic d, input logic o);
    exp_t e;
    e.led = l; e.sl = a; e.sr = b; e.dir = d; e.over = o;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got led=%h", tag, led);
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    n_assert++;
    assert (led === e.led) else begin
      n_fail++; $error("FAIL %s led: got %h expected %h", tag, led, e.led);
    end
    n_assert++;
    assert (score_l === e.sl) else begin
      n_fail++; $error("FAIL %s score_l: got %0d expected %0d", tag, score_l, e.sl);
    end
    n_assert++;
    assert (score_r === e.sr) else begin
      n_fail++; $error("FAIL %s score_r: got %0d expected %0d", tag, score_r, e.sr);
    end
    n_assert++;
    assert (ball_dir === e.dir) else begin
      n_fail++; $error("FAIL %s ball_dir: got %b expected %b", tag, ball_dir, e.dir);
    end
    n_assert++;
    assert (game_over === e.over) else begin
      n_fail++; $error("FAIL %s game_over: got %b expected %b", tag, game_over, e.over);
    end
  endtask

  task automatic do_step();
    @(negedge clk);
    clk_game = 1'b1;
    repeat (6) @(negedge clk);
    clk_game = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic press(input logic left);
    @(negedge clk);
    if (left) btn_l = 1'b1;
    else      btn_r = 1'b1;
    repeat (6) @(negedge clk);
    btn_l = 1'b0;
    btn_r = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic step_with_hit_r();
    @(negedge clk);
    clk_game = 1'b1;
    btn_r    = 1'b1;
    repeat (6) @(negedge clk);
    clk_game = 1'b0;
    btn_r    = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Flash lasts four steps; the first three still show all-on, the fourth leaves it.
  task automatic flash_steps(input string tag);
    for (int i = 0; i < 3; i++) begin
      expect_out(16'hFFFF, sl, sr, ball_dir, 1'b0);
      do_step();
      check_out(tag);
    end
  endtask

  // From SERVE_R: right serves, left returns at the left end, right misses.
  task automatic left_point_from_serve_r();
    press(1'b0);
    repeat (15) do_step();
    press(1'b1);
    repeat (15) do_step();
    do_step();
    sl = sl + 4'd1;
    expect_out(16'hFFFF, sl, sr, 1'b0, 1'b0);
    check_out("t6_point");
    flash_steps("t6_flash");
    if (sl < 4'd9) expect_out(16'h0001, sl, sr, 1'b1, 1'b0);
    else           expect_out(16'h5555, sl, sr, 1'b0, 1'b1);
    do_step();
    check_out("t6_after_flash");
  endtask

  initial begin
    // 1: reset and idle
    expect_out(16'h8000, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_out("t1_in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_out(16'h8000, 4'd0, 4'd0, 1'b0, 1'b0);
      do_step();
      check_out("t1_idle_step");
    end
    expect_out(16'h8000, 4'd0, 4'd0, 1'b0, 1'b0);
    press(1'b0);
    check_out("t1_hit_r_in_serve_l");

    // 2: serve and walk to the right end
    expect_out(16'h8000, 4'd0, 4'd0, 1'b0, 1'b0);
    press(1'b1);
    check_out("t2_serve");
    for (int i = 1; i <= 15; i++) begin
      expect_out(one << (15 - i), 4'd0, 4'd0, 1'b0, 1'b0);
      do_step();
      check_out("t2_walk");
      if (i == 7) begin
        expect_out(one << 8, 4'd0, 4'd0, 1'b0, 1'b0);
        press(1'b0);
        check_out("t2_early_hit_r");
      end
    end

    // 3: right returns at the end LED
    expect_out(16'h0001, 4'd0, 4'd0, 1'b1, 1'b0);
    press(1'b0);
    check_out("t3_return");
    for (int i = 1; i <= 15; i++) begin
      expect_out(one << i, 4'd0, 4'd0, 1'b1, 1'b0);
      do_step();
      check_out("t3_walk_left");
    end
    expect_out(16'h8000, 4'd0, 4'd0, 1'b0, 1'b0);
    press(1'b1);
    check_out("t3_left_return");
    repeat (15) do_step();

    // 4: right misses, left scores
    expect_out(16'h0001, 4'd0, 4'd0, 1'b0, 1'b0);
    check_out("t4_at_end");
    sl = 4'd1;
    expect_out(16'hFFFF, sl, sr, 1'b0, 1'b0);
    do_step();
    check_out("t4_point");
    flash_steps("t4_flash");
    expect_out(16'h0001, sl, sr, 1'b1, 1'b0);
    do_step();
    check_out("t4_serve_r");

    // right serves, left misses
    press(1'b0);
    repeat (15) do_step();
    expect_out(16'h8000, sl, sr, 1'b1, 1'b0);
    check_out("t4_at_left_end");
    sr = 4'd1;
    expect_out(16'hFFFF, sl, sr, 1'b1, 1'b0);
    do_step();
    check_out("t4_point_r");
    flash_steps("t4_flash_r");
    expect_out(16'h8000, sl, sr, 1'b0, 1'b0);
    do_step();
    check_out("t4_serve_l");

    // 5: return coincident with step at pos 0
    press(1'b1);
    repeat (15) do_step();
    expect_out(16'h0001, sl, sr, 1'b1, 1'b0);
    step_with_hit_r();
    check_out("t5_coincident");
    expect_out(16'h0002, sl, sr, 1'b1, 1'b0);
    do_step();
    check_out("t5_moves_on");
    repeat (14) do_step();
    sr = 4'd2;
    expect_out(16'hFFFF, sl, sr, 1'b1, 1'b0);
    do_step();
    check_out("t5_point_r");
    flash_steps("t5_flash");
    expect_out(16'h8000, sl, sr, 1'b0, 1'b0);
    do_step();
    check_out("t5_serve_l");

    // 6: left wins the game
    press(1'b1);
    repeat (16) do_step();
    sl = sl + 4'd1;
    expect_out(16'hFFFF, sl, sr, 1'b0, 1'b0);
    check_out("t6_first_point");
    flash_steps("t6_flash0");
    expect_out(16'h0001, sl, sr, 1'b1, 1'b0);
    do_step();
    check_out("t6_serve_r0");
    while (sl < 4'd9) left_point_from_serve_r();

    expect_out(16'hAAAA, 4'd9, 4'd2, 1'b0, 1'b1);
    do_step();
    check_out("t6_over_toggle");
    expect_out(16'hAAAA, 4'd9, 4'd2, 1'b0, 1'b1);
    press(1'b1);
    check_out("t6_over_btn");
    expect_out(16'h5555, 4'd9, 4'd2, 1'b0, 1'b1);
    do_step();
    check_out("t6_over_toggle2");

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expect_out(16'h8000, 4'd0, 4'd0, 1'b0, 1'b0);
    #1;
    check_out("t6_async_reset");
    rst_n = 1'b1;
    expect_out(16'h8000, 4'd0, 4'd0, 1'b0, 1'b0);
    do_step();
    check_out("t6_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
